// File: rtl/imuldiv_int_mul_multi_operand.sv
// N-operand integer multiplier: sequential radix-2 shift-add over operand magnitudes,
// with a single sign fix-up over the full result width at the end.
module imuldiv_int_mul_multi_operand #(
  parameter int unsigned W     = 32,
  parameter int unsigned N_OPS = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_msg_signed,
  input  logic [2:0]         req_msg_nops,
  input  logic [N_OPS*W-1:0] req_msg_ops,
  input  logic               req_val,
  output logic               req_rdy,
  output logic [N_OPS*W-1:0] resp_msg_result,
  output logic               resp_val,
  input  logic               resp_rdy
);

  localparam int unsigned R  = N_OPS * W;
  localparam int unsigned BW = $clog2(W);

  typedef enum logic [1:0] {IDLE, MUL, SIGN, RESP} state_t;

  state_t        state_q, state_d;
  logic [R-1:0]  mag_q, mag_d;
  logic [R-1:0]  prod_q, prod_d;
  logic [R-1:0]  acc_q, acc_d;
  logic [W-1:0]  mult_q, mult_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [2:0]    idx_q, idx_d;
  logic [2:0]    n_q, n_d;
  logic          sign_q, sign_d;
  logic          req_rdy_d, resp_val_d;
  logic [R-1:0]  result_d;

  logic [R-1:0]  mag_in;
  logic          sign_in;
  logic [2:0]    n_in;
  logic [R-1:0]  acc_nx;
  int            nxt;

  // Clamp operand count, take magnitudes and fold operand signs of the incoming request
  always_comb begin
    n_in = req_msg_nops;
    if (req_msg_nops < 3'd2)
      n_in = 3'd2;
    else if (req_msg_nops > 3'(N_OPS))
      n_in = 3'(N_OPS);
    mag_in  = '0;
    sign_in = 1'b0;
    for (int i = 0; i < int'(N_OPS); i++) begin
      if (req_msg_signed && req_msg_ops[i*W + W-1])
        mag_in[i*W +: W] = W'(-req_msg_ops[i*W +: W]);
      else
        mag_in[i*W +: W] = req_msg_ops[i*W +: W];
      if (req_msg_signed && (i < int'(n_in)))
        sign_in = sign_in ^ req_msg_ops[i*W + W-1];
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d    = state_q;
    mag_d      = mag_q;
    prod_d     = prod_q;
    acc_d      = acc_q;
    mult_d     = mult_q;
    bit_d      = bit_q;
    idx_d      = idx_q;
    n_d        = n_q;
    sign_d     = sign_q;
    resp_val_d = resp_val;
    result_d   = resp_msg_result;
    acc_nx     = acc_q;
    nxt        = int'(idx_q) + 1;

    case (state_q)
      IDLE: begin
        if (req_val && req_rdy) begin
          state_d = MUL;
          mag_d   = mag_in;
          prod_d  = R'(mag_in[W-1:0]);
          mult_d  = mag_in[W +: W];
          acc_d   = '0;
          bit_d   = '0;
          idx_d   = 3'd1;
          n_d     = n_in;
          sign_d  = sign_in;
        end
      end
      MUL: begin
        if (idx_q == n_q) begin
          state_d = SIGN;
        end else begin
          acc_nx = mult_q[0] ? acc_q + (prod_q << bit_q) : acc_q;
          mult_d = mult_q >> 1;
          bit_d  = bit_q + BW'(1);
          acc_d  = acc_nx;
          // Last multiplier bit: partial product becomes the new multiplicand
          if (bit_q == BW'(W-1)) begin
            prod_d = acc_nx;
            acc_d  = '0;
            bit_d  = '0;
            idx_d  = idx_q + 3'd1;
            mult_d = (nxt < int'(n_q)) ? mag_q[nxt*W +: W] : '0;
          end
        end
      end
      SIGN: begin
        result_d   = sign_q ? R'(-prod_q) : prod_q;
        resp_val_d = 1'b1;
        state_d    = RESP;
      end
      RESP: begin
        if (resp_rdy) begin
          resp_val_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    req_rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      mag_q           <= '0;
      prod_q          <= '0;
      acc_q           <= '0;
      mult_q          <= '0;
      bit_q           <= '0;
      idx_q           <= '0;
      n_q             <= 3'd2;
      sign_q          <= 1'b0;
      req_rdy         <= 1'b1;
      resp_val        <= 1'b0;
      resp_msg_result <= '0;
    end else begin
      state_q         <= state_d;
      mag_q           <= mag_d;
      prod_q          <= prod_d;
      acc_q           <= acc_d;
      mult_q          <= mult_d;
      bit_q           <= bit_d;
      idx_q           <= idx_d;
      n_q             <= n_d;
      sign_q          <= sign_d;
      req_rdy         <= req_rdy_d;
      resp_val        <= resp_val_d;
      resp_msg_result <= result_d;
    end
  end

endmodule

// File: tb/tb_imuldiv_int_mul_multi_operand.sv
// Scoreboard bench: directed W=32/N_OPS=3 vectors plus a W=16/N_OPS=4 sweep against a reference product.
module tb_imuldiv_int_mul_multi_operand;

  typedef struct {
    logic [95:0] res;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: W=32, N_OPS=3
  logic        a_sgn, a_req_val, a_req_rdy, a_resp_val, a_resp_rdy;
  logic [2:0]  a_nops;
  logic [95:0] a_ops, a_res;
  exp_t        q_a[$];
  int          a_acc_cyc = 0;
  int          rdy_delay = 0;

  imuldiv_int_mul_multi_operand #(.W(32), .N_OPS(3)) dut_a (
    .clk(clk), .reset(reset),
    .req_msg_signed(a_sgn), .req_msg_nops(a_nops), .req_msg_ops(a_ops),
    .req_val(a_req_val), .req_rdy(a_req_rdy),
    .resp_msg_result(a_res), .resp_val(a_resp_val), .resp_rdy(a_resp_rdy)
  );

  // DUT B: W=16, N_OPS=4
  logic        b_sgn, b_req_val, b_req_rdy, b_resp_val, b_resp_rdy;
  logic [2:0]  b_nops;
  logic [63:0] b_ops, b_res;
  exp_t        q_b[$];
  int          b_acc_cyc = 0;

  imuldiv_int_mul_multi_operand #(.W(16), .N_OPS(4)) dut_b (
    .clk(clk), .reset(reset),
    .req_msg_signed(b_sgn), .req_msg_nops(b_nops), .req_msg_ops(b_ops),
    .req_val(b_req_val), .req_rdy(b_req_rdy),
    .resp_msg_result(b_res), .resp_val(b_resp_val), .resp_rdy(b_resp_rdy)
  );

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int clamp_n(input int nops, input int nmax);
    if (nops < 2) return 2;
    if (nops > nmax) return nmax;
    return nops;
  endfunction

  function automatic logic [63:0] gold16(input logic sgn, input int n, input logic [63:0] ops);
    longint             sp;
    logic [63:0]        up;
    logic signed [15:0] s;
    sp = 1;
    up = 64'd1;
    for (int i = 0; i < n; i++) begin
      s  = ops[i*16 +: 16];
      sp = sp * longint'(s);
      up = up * {48'd0, ops[i*16 +: 16]};
    end
    return sgn ? 64'(sp) : up;
  endfunction

  // Called in the post-edge phase; returns in the post-edge phase after the accept edge
  task automatic send_a(input logic sgn, input logic [2:0] nops, input logic [31:0] o0,
                        input logic [31:0] o1, input logic [31:0] o2,
                        input logic [95:0] exp_res, input int lat, input bit push);
    int t = 0;
    exp_t e;
    while (!a_req_rdy && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    if (!a_req_rdy) begin
      n_cmp++; n_bad++;
      $display("FAIL a_req_rdy_timeout: req_rdy still %b after %0d cycles, expected 1", a_req_rdy, t);
      return;
    end
    a_sgn = sgn; a_nops = nops; a_ops = {o2, o1, o0}; a_req_val = 1'b1;
    a_acc_cyc = cyc + 1;
    if (push) begin
      e.res = exp_res; e.lat = lat;
      q_a.push_back(e);
    end
    @(posedge clk); #1;
    a_req_val = 1'b0;
    a_sgn = 1'($urandom); a_nops = 3'($urandom);
    a_ops = {$urandom, $urandom, $urandom};
  endtask

  task automatic send_b(input logic sgn, input logic [2:0] nops, input logic [63:0] ops);
    int t = 0;
    int n;
    exp_t e;
    while (!b_req_rdy && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    if (!b_req_rdy) begin
      n_cmp++; n_bad++;
      $display("FAIL b_req_rdy_timeout: req_rdy still %b after %0d cycles, expected 1", b_req_rdy, t);
      return;
    end
    n = clamp_n(int'(nops), 4);
    b_sgn = sgn; b_nops = nops; b_ops = ops; b_req_val = 1'b1;
    b_acc_cyc = cyc + 1;
    e.res = 96'(gold16(sgn, n, ops));
    e.lat = (n - 1) * 16 + 2;
    q_b.push_back(e);
    @(posedge clk); #1;
    b_req_val = 1'b0;
    b_ops = {$urandom, $urandom};
  endtask

  // Response-ready driver for A: hold resp_rdy low for rdy_delay cycles of each response
  initial begin
    int wc = 0;
    a_resp_rdy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (a_resp_val && !reset) begin
        if (wc >= rdy_delay) a_resp_rdy = 1'b1;
        else begin
          a_resp_rdy = 1'b0;
          wc++;
        end
      end else begin
        a_resp_rdy = 1'b0;
        wc = 0;
      end
    end
  end

  // Monitor A
  logic        pv_a = 1'b0, hs_a = 1'b0;
  logic [95:0] pr_a = '0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      pv_a = 1'b0; hs_a = 1'b0;
    end else begin
      if (hs_a) check("a_req_rdy_after_handshake", 96'(a_req_rdy), 96'd1);
      if (pv_a && !hs_a) begin
        check("a_resp_val_held", 96'(a_resp_val), 96'd1);
        check("a_result_held", a_res, pr_a);
      end
      if (a_resp_val) check("a_req_rdy_low_busy", 96'(a_req_rdy), 96'd0);
      if (a_resp_val && !pv_a) begin
        if (q_a.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL a_unexpected_resp: got result %h, expected no response", a_res);
        end else
          check("a_latency", 96'(cyc - a_acc_cyc), 96'(q_a[0].lat));
      end
      hs_a = a_resp_val && a_resp_rdy;
      if (hs_a && q_a.size() != 0) begin
        e = q_a.pop_front();
        check("a_result", a_res, e.res);
      end
      pv_a = a_resp_val;
      pr_a = a_res;
    end
  end

  // Monitor B
  logic pv_b = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) pv_b = 1'b0;
    else begin
      if (b_resp_val && !pv_b) begin
        if (q_b.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL b_unexpected_resp: got result %h, expected no response", b_res);
        end else
          check("b_latency", 96'(cyc - b_acc_cyc), 96'(q_b[0].lat));
      end
      if (b_resp_val && b_resp_rdy && q_b.size() != 0) begin
        e = q_b.pop_front();
        check("b_result", 96'(b_res), e.res);
      end
      pv_b = b_resp_val;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit hit at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    reset = 1'b1;
    a_sgn = 1'b0; a_nops = 3'd2; a_ops = '0; a_req_val = 1'b0;
    b_sgn = 1'b0; b_nops = 3'd2; b_ops = '0; b_req_val = 1'b0; b_resp_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("reset_req_rdy", 96'(a_req_rdy), 96'd1);
    check("reset_resp_val", 96'(a_resp_val), 96'd0);
    check("reset_result", a_res, 96'd0);
    check("reset_b_req_rdy", 96'(b_req_rdy), 96'd1);

    send_a(1'b0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 96'hFFFFFFFD_00000002_FFFFFFFF, 66, 1'b1);
    send_a(1'b1, 3'd3, 32'h80000000, 32'h80000000, 32'h80000000, 96'hE0000000_00000000_00000000, 66, 1'b1);
    send_a(1'b1, 3'd2, 32'hFFFFFFFD, 32'd5, 32'hDEADBEEF, 96'hFFFFFFFF_FFFFFFFF_FFFFFFF1, 34, 1'b1);
    send_a(1'b1, 3'd7, 32'd2, 32'd3, 32'hFFFFFFFF, 96'hFFFFFFFF_FFFFFFFF_FFFFFFFA, 66, 1'b1);
    send_a(1'b0, 3'd0, 32'd6, 32'd7, 32'h12345678, 96'h2A, 34, 1'b1);
    send_a(1'b0, 3'd2, 32'h00010000, 32'h00010000, 32'hFFFFFFFF, 96'h00000000_00000001_00000000, 34, 1'b1);
    send_a(1'b0, 3'd3, 32'h80000000, 32'd2, 32'd3, 96'h00000000_00000003_00000000, 66, 1'b1);

    // Backpressure on the response, then a back-to-back request
    rdy_delay = 10;
    send_a(1'b1, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 96'h5, 66, 1'b1);
    send_a(1'b1, 3'd3, 32'd3, 32'hFFFFFFFF, 32'd4, 96'hFFFFFFFF_FFFFFFFF_FFFFFFF4, 66, 1'b1);
    rdy_delay = 0;

    // Abandon a job mid-multiply with reset
    send_a(1'b0, 3'd3, 32'h11111111, 32'h22222222, 32'h33333333, 96'd0, 66, 1'b0);
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_resp_val", 96'(a_resp_val), 96'd0);
    check("midreset_req_rdy", 96'(a_req_rdy), 96'd1);
    reset = 1'b0;
    send_a(1'b1, 3'd3, 32'd7, 32'hFFFFFFFA, 32'd2, 96'hFFFFFFFF_FFFFFFFF_FFFFFFAC, 66, 1'b1);
    send_a(1'b1, 3'd3, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 96'd0, 66, 1'b1);

    // W=16, N_OPS=4: every nops encoding, both modes, extreme and random operands
    for (int s = 0; s < 2; s++) begin
      for (int nops = 0; nops < 8; nops++) begin
        for (int k = 0; k < 4; k++) begin
          logic [63:0] ops;
          case (k)
            0:       ops = {4{16'h8000}};
            1:       ops = {4{16'hFFFF}};
            2:       ops = {16'h7FFF, 16'h0000, 16'h8001, 16'h0003};
            default: ops = {$urandom, $urandom};
          endcase
          send_b(1'(s), 3'(nops), ops);
        end
      end
    end

    t = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && t < 3000) begin
      @(posedge clk);
      t++;
    end
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: %0d/%0d responses outstanding, expected 0/0", q_a.size(), q_b.size());
    end
    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
